// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the transmitter (pcm_to_i2s) and the receiver.
// Holds the default geometry, the word-select encoding and the frame-index width helper.
package i2s_pkg;

  localparam int DEFAULT_NUMBER_OF_BITS = 8;
  localparam int DEFAULT_SLOT_BITS      = 32;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Width of a counter that spans one full frame of 2*slot_bits bit clocks.
  function automatic int frame_idx_width(input int slot_bits);
    return $clog2(2 * slot_bits);
  endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Free-running frame counter for the I2S master: owns the frame index, word select,
// the frame_start marker and the strobe that loads a new active pair at the end of F=0.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = DEFAULT_SLOT_BITS,
  parameter int FW        = frame_idx_width(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [FW-1:0] frame_idx,
  output logic          ws,
  output logic          frame_start,
  output logic          load
);

  localparam logic [FW-1:0] LAST_IDX  = FW'(2 * SLOT_BITS - 1);
  localparam logic [FW-1:0] RIGHT_IDX = FW'(SLOT_BITS);

  logic [FW-1:0] f_q;
  logic [FW-1:0] f_d;

  always_comb begin
    f_d = f_q + FW'(1);
    if (f_q == LAST_IDX) begin
      f_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign frame_idx = f_q;
  assign ws        = (f_q >= RIGHT_IDX) ? WS_RIGHT : WS_LEFT;

  // F=0 is only a real frame start once reset has been released.
  assign frame_start = (f_q == '0) && !reset;
  assign load        = frame_start;

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S master transmitter: takes stereo PCM pairs over valid/ready and shifts them out
// MSB first, one bit clock after each WS edge, zero-padded to the slot width.
module pcm_to_i2s
  import i2s_pkg::*;
#(
  parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
  parameter int SLOT_BITS      = DEFAULT_SLOT_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUMBER_OF_BITS-1:0] sample_left,
  input  logic [NUMBER_OF_BITS-1:0] sample_right,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam int W  = NUMBER_OF_BITS;
  localparam int FW = frame_idx_width(SLOT_BITS);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  generate
    if (SLOT_BITS < NUMBER_OF_BITS + 1) begin : g_bad_slot
      $error("pcm_to_i2s: SLOT_BITS must be at least NUMBER_OF_BITS+1");
    end
  endgenerate

  logic [FW-1:0] frame_idx;
  logic          load;

  i2s_frame_timer #(
    .SLOT_BITS (SLOT_BITS),
    .FW        (FW)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_idx   (frame_idx),
    .ws          (ws),
    .frame_start (frame_start),
    .load        (load)
  );

  logic         full_q,     full_d;
  logic [W-1:0] hold_l_q,   hold_l_d;
  logic [W-1:0] hold_r_q,   hold_r_d;
  logic [W-1:0] act_l_q,    act_l_d;
  logic [W-1:0] act_r_q,    act_r_d;
  logic         underrun_q, underrun_d;
  logic         accept;

  // Handshake: a pair transfers on a rising edge where sample_valid && sample_ready.
  // Ready is low while the holding register is full or reset is asserted; inputs are
  // ignored then and the held pair is never overwritten.
  assign sample_ready = !full_q && !reset;
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    act_l_d    = act_l_q;
    act_r_d    = act_r_q;
    underrun_d = 1'b0;
    if (load) begin
      if (full_q) begin
        act_l_d = hold_l_q;
        act_r_d = hold_r_q;
        full_d  = 1'b0;
      end else begin
        act_l_d    = '0;
        act_r_d    = '0;
        underrun_d = 1'b1;
      end
    end
    // Accept only happens when full_q is clear, so it never races the load above.
    if (accept) begin
      hold_l_d = sample_left;
      hold_r_d = sample_right;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      act_l_q    <= '0;
      act_r_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;

  int           f_int;
  logic         in_left;
  logic         in_right;
  logic [IW-1:0] bit_idx;
  logic         sd_bit;

  // Data window starts one bit clock after each WS edge; everything else pads with zero.
  always_comb begin
    f_int    = int'(frame_idx);
    in_left  = (f_int >= 1) && (f_int <= W);
    in_right = (f_int >= SLOT_BITS + 1) && (f_int <= SLOT_BITS + W);
    bit_idx  = '0;
    sd_bit   = 1'b0;
    if (in_left) begin
      bit_idx = IW'(W - f_int);
      sd_bit  = act_l_q[bit_idx];
    end else if (in_right) begin
      bit_idx = IW'(SLOT_BITS + W - f_int);
      sd_bit  = act_r_q[bit_idx];
    end
  end

  assign sd = sd_bit;

endmodule
